// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple dual-port RAM and its clear engine.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  // True when an address maps onto a real word; matters only for non-power-of-two depths.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear engine: zeroes every word once after reset and again whenever clr is pulsed.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  ram_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        CLEAR: begin
          if (clr) begin
            cnt_q <= '0;
          end else if (cnt_q == LastAddr) begin
            state_q <= READY;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        READY: begin
          if (clr) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/simple_dual_port_ram.sv
// One-write/one-read RAM with registered read, write-first bypass and a built-in clear engine.
module simple_dual_port_ram
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  ram_clear_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A clr request in READY already blocks accesses in its own cycle.
  logic access_ok;
  logic wr_fire;
  logic rd_fire;
  logic rd_in_range;

  assign access_ok   = ~busy & ~clr;
  assign wr_fire     = access_ok & wr_en & addr_in_range(32'(wr_addr), DEPTH);
  assign rd_fire     = access_ok & rd_en;
  assign rd_in_range = addr_in_range(32'(rd_addr), DEPTH);

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    mem_we    = clr_we | wr_fire;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (clr_we) begin
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  logic [DATA_W-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if (wr_fire && (wr_addr == rd_addr)) begin
        rd_word = wr_data;
      end else begin
        rd_word = mem_q[rd_addr];
      end
    end
  end

  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_data_q <= rd_word;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_simple_dual_port_ram.sv
// Directed bench: a 128x8 instance and a 100x16 instance exercised in sequence.
module tb_simple_dual_port_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, clr_a, wr_en_a, rd_en_a, rd_valid_a, busy_a;
  logic [6:0] wr_addr_a, rd_addr_a;
  logic [7:0] wr_data_a, rd_data_a;

  logic        rst_b, clr_b, wr_en_b, rd_en_b, rd_valid_b, busy_b;
  logic [6:0]  wr_addr_b, rd_addr_b;
  logic [15:0] wr_data_b, rd_data_b;

  int checks   = 0;
  int failures = 0;

  simple_dual_port_ram #(
    .DATA_W (8),
    .DEPTH  (128)
  ) u_dut_a (
    .clk      (clk),
    .rst      (rst_a),
    .clr      (clr_a),
    .wr_en    (wr_en_a),
    .wr_addr  (wr_addr_a),
    .wr_data  (wr_data_a),
    .rd_en    (rd_en_a),
    .rd_addr  (rd_addr_a),
    .rd_data  (rd_data_a),
    .rd_valid (rd_valid_a),
    .busy     (busy_a)
  );

  simple_dual_port_ram #(
    .DATA_W (16),
    .DEPTH  (100)
  ) u_dut_b (
    .clk      (clk),
    .rst      (rst_b),
    .clr      (clr_b),
    .wr_en    (wr_en_b),
    .wr_addr  (wr_addr_b),
    .wr_data  (wr_data_b),
    .rd_en    (rd_en_b),
    .rd_addr  (rd_addr_b),
    .rd_data  (rd_data_b),
    .rd_valid (rd_valid_b),
    .busy     (busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy_a(output int n);
    n = 0;
    while (busy_a && n < 300) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [7:0] exp_a [5];
    exp_a[0] = 8'h10; exp_a[1] = 8'h11; exp_a[2] = 8'h12; exp_a[3] = 8'h13; exp_a[4] = 8'h00;

    rst_a = 1'b1; clr_a = 1'b0; wr_en_a = 1'b0; rd_en_a = 1'b0;
    wr_addr_a = '0; rd_addr_a = '0; wr_data_a = '0;
    rst_b = 1'b1; clr_b = 1'b0; wr_en_b = 1'b0; rd_en_b = 1'b0;
    wr_addr_b = '0; rd_addr_b = '0; wr_data_b = '0;

    tick();
    chk("rst_busy", 32'(busy_a), 32'h1);
    chk("rst_rd_valid", 32'(rd_valid_a), 32'h0);
    chk("rst_rd_data", 32'(rd_data_a), 32'h0);
    tick();
    rst_a = 1'b0;
    count_busy_a(n);
    chk("init_clear_cycles", 32'(n), 32'd128);

    // Post-clear contents are all zero, each read pulses rd_valid
    for (int i = 0; i < 128; i++) begin
      rd_en_a = 1'b1; rd_addr_a = 7'(i);
      tick();
      chk("init_read_valid", 32'(rd_valid_a), 32'h1);
      chk("init_read_data", 32'(rd_data_a), 32'h0);
    end
    rd_en_a = 1'b0;
    tick();
    chk("idle_valid_low", 32'(rd_valid_a), 32'h0);

    for (int i = 0; i < 4; i++) begin
      wr_en_a = 1'b1; wr_addr_a = 7'(i); wr_data_a = 8'(8'h10 + i);
      tick();
    end
    wr_en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_en_a = 1'b1; rd_addr_a = 7'(i);
      tick();
      chk("b2b_valid", 32'(rd_valid_a), 32'h1);
      chk("b2b_data", 32'(rd_data_a), 32'(exp_a[i]));
    end
    rd_en_a = 1'b0;

    // Same-cycle write and read of address 5
    wr_en_a = 1'b1; wr_addr_a = 7'd5; wr_data_a = 8'hA5;
    rd_en_a = 1'b1; rd_addr_a = 7'd5;
    tick();
    wr_en_a = 1'b0; rd_en_a = 1'b0;
    chk("bypass_valid", 32'(rd_valid_a), 32'h1);
    chk("bypass_data", 32'(rd_data_a), 32'hA5);
    tick();
    chk("hold_valid", 32'(rd_valid_a), 32'h0);
    chk("hold_data", 32'(rd_data_a), 32'hA5);

    // clr with accesses attempted throughout the clear
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    chk("clr_busy", 32'(busy_a), 32'h1);
    wr_en_a = 1'b1; wr_addr_a = 7'd2; wr_data_a = 8'h77;
    rd_en_a = 1'b1; rd_addr_a = 7'd2;
    n = 0;
    while (busy_a && n < 300) begin
      tick();
      n++;
      chk("clr_rd_ignored", 32'(rd_valid_a), 32'h0);
    end
    wr_en_a = 1'b0; rd_en_a = 1'b0;
    chk("clr_cycles", 32'(n), 32'd128);
    rd_en_a = 1'b1; rd_addr_a = 7'd2;
    tick();
    chk("clr_read2_valid", 32'(rd_valid_a), 32'h1);
    chk("clr_read2_data", 32'(rd_data_a), 32'h0);
    rd_addr_a = 7'd5;
    tick();
    rd_en_a = 1'b0;
    chk("clr_read5_data", 32'(rd_data_a), 32'h0);

    // Reset in the middle of a clear
    wr_en_a = 1'b1; wr_addr_a = 7'd7; wr_data_a = 8'h3C;
    tick();
    wr_en_a = 1'b0; rd_en_a = 1'b1; rd_addr_a = 7'd7;
    tick();
    rd_en_a = 1'b0;
    chk("pre_rst_data", 32'(rd_data_a), 32'h3C);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    chk("mid_clear_busy", 32'(busy_a), 32'h1);
    rst_a = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy_a), 32'h1);
    chk("mid_rst_data", 32'(rd_data_a), 32'h0);
    chk("mid_rst_valid", 32'(rd_valid_a), 32'h0);
    tick();
    rst_a = 1'b0;
    count_busy_a(n);
    chk("mid_rst_clear_cycles", 32'(n), 32'd128);
    rd_en_a = 1'b1; rd_addr_a = 7'd7;
    tick();
    rd_en_a = 1'b0;
    chk("mid_rst_read7", 32'(rd_data_a), 32'h0);

    // 100x16 instance: non-power-of-two depth
    rst_b = 1'b0;
    n = 0;
    while (busy_b && n < 300) begin
      tick();
      n++;
    end
    chk("b_clear_cycles", 32'(n), 32'd100);
    wr_en_b = 1'b1; wr_addr_b = 7'd99; wr_data_b = 16'hBEEF;
    tick();
    wr_en_b = 1'b0; rd_en_b = 1'b1; rd_addr_b = 7'd99;
    tick();
    rd_en_b = 1'b0;
    chk("b_read99_valid", 32'(rd_valid_b), 32'h1);
    chk("b_read99_data", 32'(rd_data_b), 32'hBEEF);
    wr_en_b = 1'b1; wr_addr_b = 7'd120; wr_data_b = 16'h1234;
    tick();
    wr_en_b = 1'b0; rd_en_b = 1'b1; rd_addr_b = 7'd120;
    tick();
    chk("b_oor_valid", 32'(rd_valid_b), 32'h1);
    chk("b_oor_data", 32'(rd_data_b), 32'h0);
    rd_addr_b = 7'd99;
    tick();
    rd_en_b = 1'b0;
    chk("b_read99_after", 32'(rd_data_b), 32'hBEEF);
    rd_en_b = 1'b1; rd_addr_b = 7'd20;
    tick();
    rd_en_b = 1'b0;
    chk("b_read20_alias", 32'(rd_data_b), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
